uart_rx_ctrl: RTL and testbench
===============================

// Module: uart_rx_ctrl
// PURPOSE
//  Byte-wide UART receiver (8N1, LSB first) at the BLE command input of the Segway.
//  Oversamples the asynchronous RX pin with the system clock and samples each bit at its centre.
//  Presents each received byte through a rdy/clr_rdy handshake to the auth/command logic.
//  Flags framing and overrun errors.
// PARAMETERS
//  BAUD_CYCLES  2604  clk cycles per bit (50 MHz / 19200 baud)
//  HALF_CYCLES  1302  clk cycles from the start-bit falling edge to the start-bit centre
// PORTS
//  clk      in   1  system clock, 50 MHz; all logic on posedge clk
//  rst_n    in   1  asynchronous active-low reset (synchronized deassertion from rst_synch)
//  RX       in   1  asynchronous serial input; idle high
//  clr_rdy  in   1  consumer ack; clears rdy, frm_err and ovr_err
//  rx_data  out  8  last good byte received
//  rdy      out  1  a byte is valid in rx_data; high until clr_rdy
//  frm_err  out  1  sticky: stop bit sampled low
//  ovr_err  out  1  sticky: byte completed while rdy was still high
// BEHAVIOUR
//  - Reset: rx_data=8'h00, rdy=0, frm_err=0, ovr_err=0, state=IDLE, sync flops preset to 1.
//  - RX passes through a 2-flop synchronizer. Falling-edge detect uses a third flop.
//  - Counters:
//    - baud_cnt is 12 bits and counts down; it reloads on every state entry.
//    - bit_cnt is 4 bits.
//  - FSM states:
//    - IDLE:  on a synced falling edge, load HALF_CYCLES and go to START.
//    - START: at baud_cnt==0, sample RX.
//      - RX==0: load BAUD_CYCLES, clear bit_cnt, go to DATA.
//      - RX==1: false start; go to IDLE with no flag.
//    - DATA:  at each baud_cnt==0, shift RX into shreg[7] (right shift, so LSB is first).
//      - Increment bit_cnt and reload BAUD_CYCLES.
//      - When bit_cnt reaches 8, go to STOP.
//    - STOP:  at baud_cnt==0, sample RX.
//      - RX==1: rx_data<=shreg and rdy<=1. If rdy was already 1 and clr_rdy is low, ovr_err<=1
//        (rx_data is overwritten). Go to IDLE.
//      - RX==0: frm_err<=1. rdy and rx_data are unchanged. Go to IDLE.
//        IDLE waits for RX high before the next falling edge is possible.
//  - Latency: rdy rises HALF_CYCLES + 9*BAUD_CYCLES + 3 clocks after the RX pin falling edge (+/-1).
//  - clr_rdy: clears rdy, frm_err and ovr_err on the next edge.
//    - Coincident with a good-byte completion: set wins. rdy=1, new data loaded, ovr_err not set.
//    - Coincident with a framing error: frm_err=1, rdy=0.
//  - clr_rdy while rdy=0 has no effect beyond clearing the error flags.
//  - Reception continues regardless of rdy; there is no back-pressure on the line.
//  - RX held low indefinitely (break): one frm_err, then the FSM stays in IDLE until RX goes high.
//  - Async reset mid-byte aborts immediately to the reset values.
//  - Outputs are registered; there are no combinational paths from RX or clr_rdy to outputs.
// STRUCTURE
//  - Shared package uart_pkg:
//    - typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t
//    - localparam BAUD_19200_50M = 2604
//    - command byte constants G = 8'h47, S = 8'h53 (shared with the bench tasks)
//  - One flat module; no sub-module (synchronizer, counters and FSM are too small to split).
//  - Must interoperate with the existing UART_tx using the same BAUD_CYCLES.
// TESTING
//  1. UART_tx sends 8'h47 ('G') -> rdy=1 within 9.5 bit times +/-2 clk, rx_data=8'h47,
//     frm_err=0, ovr_err=0. Then pulse clr_rdy -> rdy=0.
//  2. Send 8'h53 then 8'hA5 back-to-back with no clr_rdy -> after the second byte rx_data=8'hA5,
//     rdy=1, ovr_err=1. clr_rdy -> all three flags 0.
//  3. Bench-driven frame 8'h3C with the stop bit held low -> frm_err=1, rdy=0, rx_data unchanged.
//     A following good 8'h55 -> rdy=1, rx_data=8'h55.
//  4. RX low glitch of 500 clk (< HALF_CYCLES) -> no rdy, no frm_err, FSM back in IDLE.
//     Next byte 8'h47 is received correctly.
//  5. Assert rst_n low during bit 4 of 8'hFF -> all outputs 0 immediately.
//     After release, 8'h12 is received correctly.
//  6. clr_rdy asserted on the exact cycle 8'h81 completes (rdy already 1) -> rdy=1,
//     rx_data=8'h81, ovr_err=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, 19200-baud timing at 50 MHz,
// and the BLE command byte constants used by the command logic and its benches.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_t;

   localparam int unsigned BAUD_19200_50M = 32'd2604;
   localparam int unsigned HALF_19200_50M = 32'd1302;

   localparam logic [7:0] CMD_G = 8'h47;
   localparam logic [7:0] CMD_S = 8'h53;

   // The down-counter spends one cycle at zero, so a period of N cycles loads N-1.
   function automatic logic [11:0] cnt_load(input int unsigned cycles);
      return 12'(cycles - 32'd1);
   endfunction

endpackage

// File: rtl/uart_rx_ctrl.sv
// 8N1 UART receiver: synchronizes RX, samples each bit at its centre and hands
// complete bytes to the command logic through a rdy/clr_rdy handshake.
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int unsigned BAUD_CYCLES = BAUD_19200_50M,
   parameter int unsigned HALF_CYCLES = HALF_19200_50M
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       RX,
   input  logic       clr_rdy,
   output logic [7:0] rx_data,
   output logic       rdy,
   output logic       frm_err,
   output logic       ovr_err
);

   rx_state_t   state_r, state_nxt_s;
   logic [11:0] baud_cnt_r, baud_cnt_nxt_s;
   logic [3:0]  bit_cnt_r, bit_cnt_nxt_s;
   logic [7:0]  shreg_r, shreg_nxt_s;
   logic        rx_s1_r, rx_s2_r, rx_s3_r;
   logic        fall_s, baud_zero_s, done_ok_s, done_frm_s;
   logic [7:0]  rx_data_r, rx_data_nxt_s;
   logic        rdy_r, rdy_nxt_s, frm_err_r, frm_err_nxt_s, ovr_err_r, ovr_err_nxt_s;

   // RX synchronizer plus edge-detect flop; preset high so reset never looks like a start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_s1_r <= 1'b1;
         rx_s2_r <= 1'b1;
         rx_s3_r <= 1'b1;
      end else begin
         rx_s1_r <= RX;
         rx_s2_r <= rx_s1_r;
         rx_s3_r <= rx_s2_r;
      end
   end

   assign fall_s      = rx_s3_r & ~rx_s2_r;
   assign baud_zero_s = (baud_cnt_r == 12'd0);

   // FSM state, baud/bit counters and shift register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         baud_cnt_r <= 12'd0;
         bit_cnt_r  <= 4'd0;
         shreg_r    <= 8'h00;
      end else begin
         state_r    <= state_nxt_s;
         baud_cnt_r <= baud_cnt_nxt_s;
         bit_cnt_r  <= bit_cnt_nxt_s;
         shreg_r    <= shreg_nxt_s;
      end
   end

   // Next-state logic: counter reloads on each state entry, samples at its zero.
   always_comb begin
      state_nxt_s    = state_r;
      baud_cnt_nxt_s = baud_zero_s ? baud_cnt_r : (baud_cnt_r - 12'd1);
      bit_cnt_nxt_s  = bit_cnt_r;
      shreg_nxt_s    = shreg_r;
      done_ok_s      = 1'b0;
      done_frm_s     = 1'b0;
      case (state_r)
         IDLE: begin
            if (fall_s) begin
               state_nxt_s    = START;
               baud_cnt_nxt_s = cnt_load(HALF_CYCLES);
            end else begin
               state_nxt_s = IDLE;
            end
         end
         START: begin
            if (baud_zero_s) begin
               if (!rx_s2_r) begin
                  state_nxt_s    = DATA;
                  baud_cnt_nxt_s = cnt_load(BAUD_CYCLES);
                  bit_cnt_nxt_s  = 4'd0;
               end else begin
                  state_nxt_s = IDLE;
               end
            end else begin
               state_nxt_s = START;
            end
         end
         DATA: begin
            if (baud_zero_s) begin
               shreg_nxt_s    = {rx_s2_r, shreg_r[7:1]};
               bit_cnt_nxt_s  = bit_cnt_r + 4'd1;
               baud_cnt_nxt_s = cnt_load(BAUD_CYCLES);
               if (bit_cnt_r == 4'd7) begin
                  state_nxt_s = STOP;
               end else begin
                  state_nxt_s = DATA;
               end
            end else begin
               state_nxt_s = DATA;
            end
         end
         STOP: begin
            if (baud_zero_s) begin
               state_nxt_s    = IDLE;
               baud_cnt_nxt_s = cnt_load(BAUD_CYCLES);
               if (rx_s2_r) begin
                  done_ok_s = 1'b1;
               end else begin
                  done_frm_s = 1'b1;
               end
            end else begin
               state_nxt_s = STOP;
            end
         end
         default: begin
            state_nxt_s    = IDLE;
            baud_cnt_nxt_s = 12'd0;
         end
      endcase
   end

   // Handshake flags: a completing event wins over a coincident clr_rdy.
   always_comb begin
      rx_data_nxt_s = rx_data_r;
      rdy_nxt_s     = rdy_r & ~clr_rdy;
      frm_err_nxt_s = frm_err_r & ~clr_rdy;
      ovr_err_nxt_s = ovr_err_r & ~clr_rdy;
      if (done_ok_s) begin
         rx_data_nxt_s = shreg_r;
         rdy_nxt_s     = 1'b1;
         ovr_err_nxt_s = ovr_err_nxt_s | (rdy_r & ~clr_rdy);
      end else if (done_frm_s) begin
         frm_err_nxt_s = 1'b1;
      end else begin
         rx_data_nxt_s = rx_data_r;
      end
   end

   // Registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_data_r <= 8'h00;
         rdy_r     <= 1'b0;
         frm_err_r <= 1'b0;
         ovr_err_r <= 1'b0;
      end else begin
         rx_data_r <= rx_data_nxt_s;
         rdy_r     <= rdy_nxt_s;
         frm_err_r <= frm_err_nxt_s;
         ovr_err_r <= ovr_err_nxt_s;
      end
   end

   assign rx_data = rx_data_r;
   assign rdy     = rdy_r;
   assign frm_err = frm_err_r;
   assign ovr_err = ovr_err_r;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: table of frames with expected flags,
// plus directed sequences for latency, glitch, break, reset and clr collisions.
module tb_uart_rx_ctrl;
   import uart_pkg::*;

   localparam int unsigned BAUD = 32'd16;
   localparam int unsigned HALF = 32'd8;
   localparam int          LAT  = 155;

   logic       clk;
   logic       rst_n;
   logic       RX;
   logic       clr_rdy;
   logic [7:0] rx_data;
   logic       rdy, frm_err, ovr_err;

   int n_cmp;
   int n_mis;
   int cyc;
   int fall_cyc;
   int rise_cyc;
   logic rdy_q;

   typedef struct packed {
      logic [7:0] data;
      logic       stop_b;
      logic       clr_before;
      logic [7:0] exp_data;
      logic       exp_rdy;
      logic       exp_frm;
      logic       exp_ovr;
   } vec_t;

   vec_t vecs [7];

   uart_rx_ctrl #(.BAUD_CYCLES(BAUD), .HALF_CYCLES(HALF)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .RX      (RX),
      .clr_rdy (clr_rdy),
      .rx_data (rx_data),
      .rdy     (rdy),
      .frm_err (frm_err),
      .ovr_err (ovr_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      rdy_q    = 1'b0;
      rise_cyc = 0;
   end
   always @(negedge clk) begin
      if (rdy && !rdy_q) rise_cyc = cyc;
      rdy_q = rdy;
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic check_all(input string name, input logic [7:0] d, input logic r,
                            input logic f, input logic o);
      check({name, ".rx_data"}, rx_data, d);
      check({name, ".rdy"}, {7'd0, rdy}, {7'd0, r});
      check({name, ".frm_err"}, {7'd0, frm_err}, {7'd0, f});
      check({name, ".ovr_err"}, {7'd0, ovr_err}, {7'd0, o});
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_b);
      @(negedge clk);
      RX = 1'b0;
      fall_cyc = cyc;
      repeat (BAUD) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         RX = d[i];
         repeat (BAUD) @(negedge clk);
      end
      RX = stop_b;
      repeat (BAUD) @(negedge clk);
      RX = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      clr_rdy = 1'b1;
      @(negedge clk);
      clr_rdy = 1'b0;
   endtask

   initial begin
      n_cmp   = 0;
      n_mis   = 0;
      RX      = 1'b1;
      clr_rdy = 1'b0;
      rst_n   = 1'b0;

      vecs[0] = '{8'h53, 1'b1, 1'b0, 8'h53, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b1};
      vecs[2] = '{8'h3C, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{8'h55, 1'b1, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{8'hE7, 1'b0, 1'b0, 8'h55, 1'b1, 1'b1, 1'b0};
      vecs[5] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
      vecs[6] = '{CMD_G, 1'b1, 1'b0, 8'h47, 1'b1, 1'b0, 1'b1};

      repeat (3) @(negedge clk);
      check_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // First byte with latency measurement, then clear.
      send_frame(CMD_G, 1'b1);
      check_all("first_byte", 8'h47, 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if ((rise_cyc - fall_cyc) < LAT - 2 || (rise_cyc - fall_cyc) > LAT + 2) begin
         n_mis++;
         $display("FAIL latency: got %0d clk, expected %0d +/-2", rise_cyc - fall_cyc, LAT);
      end
      pulse_clr();
      check("first_clr.rdy", {7'd0, rdy}, 8'h00);

      for (int v = 0; v < 7; v++) begin
         if (vecs[v].clr_before) pulse_clr();
         send_frame(vecs[v].data, vecs[v].stop_b);
         check_all($sformatf("vec%0d", v), vecs[v].exp_data, vecs[v].exp_rdy,
                   vecs[v].exp_frm, vecs[v].exp_ovr);
      end
      pulse_clr();
      check_all("clr_all", 8'h47, 1'b0, 1'b0, 1'b0);

      // Short low glitch is a false start.
      @(negedge clk);
      RX = 1'b0;
      repeat (5) @(negedge clk);
      RX = 1'b1;
      repeat (3 * BAUD) @(negedge clk);
      check_all("glitch", 8'h47, 1'b0, 1'b0, 1'b0);
      send_frame(CMD_G, 1'b1);
      check_all("after_glitch", 8'h47, 1'b1, 1'b0, 1'b0);

      // Break: one framing error, then silence until RX returns high.
      pulse_clr();
      @(negedge clk);
      RX = 1'b0;
      repeat (30 * BAUD) @(negedge clk);
      check_all("break", 8'h47, 1'b0, 1'b1, 1'b0);
      pulse_clr();
      repeat (15 * BAUD) @(negedge clk);
      check("break_hold.frm_err", {7'd0, frm_err}, 8'h00);
      RX = 1'b1;
      repeat (4) @(negedge clk);
      send_frame(8'h12, 1'b1);
      check_all("after_break", 8'h12, 1'b1, 1'b0, 1'b0);

      // Async reset in the middle of bit 4 of 8'hFF.
      @(negedge clk);
      RX = 1'b0;
      repeat (BAUD) @(negedge clk);
      RX = 1'b1;
      repeat (4 * BAUD + BAUD / 2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_all("mid_reset", 8'h00, 1'b0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (4 * BAUD) @(negedge clk);
      check_all("post_reset_idle", 8'h00, 1'b0, 1'b0, 1'b0);
      send_frame(8'h12, 1'b1);
      check_all("after_reset", 8'h12, 1'b1, 1'b0, 1'b0);

      // clr_rdy on the exact completion cycle: set wins, no overrun.
      fork
         send_frame(8'h81, 1'b1);
         begin
            @(negedge clk);
            repeat (LAT - 1) @(negedge clk);
            clr_rdy = 1'b1;
            @(negedge clk);
            clr_rdy = 1'b0;
         end
      join
      check_all("coincident_clr", 8'h81, 1'b1, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
